// File: rtl/somador_sequencial.sv
// somador_sequencial: multi-cycle WIDTH-bit adder, SLICE bits per clock with a registered inter-slice carry.
// Define SOMADOR_SUB_EN to add the sub input (a - b mode) and the signed overflow output ovf.
module somador_sequencial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef SOMADOR_SUB_EN
  ,
  input  logic             sub,
  output logic             ovf
`endif
);

  localparam int NSL  = (SLICE > 0) ? WIDTH / SLICE : 1;
  localparam int IDXW = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSL - 1);

  if (WIDTH < 1 || SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_param_check
    $error("somador_sequencial: SLICE must be in 1..WIDTH and divide WIDTH exactly");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;
  logic [IDXW-1:0]  idx;

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] sum_sl;
  logic             slice_co;

  // One SLICE-wide ripple step on the current slice; acc is a working copy so s stays stable during CALC.
  always_comb begin
    a_sl = a_reg[idx*SLICE +: SLICE];
    b_sl = b_reg[idx*SLICE +: SLICE];
    {slice_co, sum_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry};
    acc_next = acc;
    acc_next[idx*SLICE +: SLICE] = sum_sl;
  end

`ifdef SOMADOR_SUB_EN
  // Carry into the MSB is recovered from the MSB sum bit; only meaningful on the last slice.
  logic msb_cin;
  assign msb_cin = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ sum_sl[SLICE-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      co    <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      carry <= 1'b0;
      idx   <= '0;
`ifdef SOMADOR_SUB_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= a;
`ifdef SOMADOR_SUB_EN
            b_reg <= sub ? ~b : b;
            carry <= sub ? 1'b1 : ci;
`else
            b_reg <= b;
            carry <= ci;
`endif
            idx   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc   <= acc_next;
          carry <= slice_co;
          if (idx == LAST_IDX) begin
            s     <= acc_next;
            co    <= slice_co;
`ifdef SOMADOR_SUB_EN
            ovf   <= msb_cin ^ slice_co;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_somador_sequencial.sv
// Bench for somador_sequencial: vector table, randomized ops against an arithmetic model, handshake corner cases.
// A second instance (WIDTH=1, SLICE=1) covers the single-slice case; sub/ovf checks compile in with SOMADOR_SUB_EN.
module tb_somador_sequencial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic        sub;
  logic        busy;
  logic        done;
  logic [15:0] s;
  logic        co;
  logic        ovf;

  logic        start1;
  logic [0:0]  a1;
  logic [0:0]  b1;
  logic        ci1;
  logic        sub1;
  logic        busy1;
  logic        done1;
  logic [0:0]  s1;
  logic        co1;
  logic        ovf1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;
    logic [15:0] exp_s;
    logic        exp_co;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];

  somador_sequencial #(.WIDTH(16), .SLICE(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co)
`ifdef SOMADOR_SUB_EN
    ,
    .sub   (sub),
    .ovf   (ovf)
`endif
  );

  somador_sequencial #(.WIDTH(1), .SLICE(1)) u_dut_w1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .ci    (ci1),
    .busy  (busy1),
    .done  (done1),
    .s     (s1),
    .co    (co1)
`ifdef SOMADOR_SUB_EN
    ,
    .sub   (sub1),
    .ovf   (ovf1)
`endif
  );

`ifndef SOMADOR_SUB_EN
  assign ovf  = 1'b0;
  assign ovf1 = 1'b0;
`endif

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Full-width arithmetic reference: subtraction is a + ~b + 1, overflow from operand/result signs.
  function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic mci,
                                input logic msub, output logic [15:0] ms, output logic mco,
                                output logic movf);
    logic [16:0] full;
    logic [15:0] bb;
    logic        cin;
    bb   = msub ? ~mb : mb;
    cin  = msub ? 1'b1 : mci;
    full = {1'b0, ma} + {1'b0, bb} + {16'h0000, cin};
    ms   = full[15:0];
    mco  = full[16];
    movf = (ma[15] == bb[15]) && (ms[15] != ma[15]);
  endfunction

  // Issue one start pulse, scramble the inputs, then count edges until done (bounded).
  task automatic apply_stimulus(input logic [15:0] ia, input logic [15:0] ib, input logic ici,
                                input logic isub, output logic [15:0] os, output logic oco,
                                output logic oovf, output int lat, output int busy_cnt);
    @(negedge clk);
    a = ia; b = ib; ci = ici; sub = isub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 50) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    os   = s;
    oco  = co;
    oovf = ovf;
  endtask

  task automatic apply_stimulus_w1(input logic ia, input logic ib, input logic ici,
                                   output logic [1:0] ores, output int lat);
    @(negedge clk);
    a1 = ia; b1 = ib; ci1 = ici; sub1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    ores = {co1, s1[0]};
  endtask

  initial begin
    logic [15:0] rs;
    logic        rco;
    logic        rovf;
    logic [15:0] ms;
    logic        mco;
    logic        movf;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rci;
    logic        rsub;
    logic [1:0]  res1;
    logic [1:0]  w1_exp [8];
    logic [2:0]  combo;
    int          lat;
    int          busy_cnt;
    int          gap;
    int          done_seen;

    w1_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
    vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0});
    vecs.push_back('{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0});
`ifdef SOMADOR_SUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
    vecs.push_back('{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
`endif

    rst_n = 1'b0;
    start = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0; sub1 = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_s", 32'(s), 32'd0);
    check_output("reset_co", 32'(co), 32'd0);
    rst_n = 1'b1;

    $display("[TB] vector table");
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, rs, rco, rovf, lat, busy_cnt);
      check_output($sformatf("vec%0d_s", i), 32'(rs), 32'(vecs[i].exp_s));
      check_output($sformatf("vec%0d_co", i), 32'(rco), 32'(vecs[i].exp_co));
`ifdef SOMADOR_SUB_EN
      check_output($sformatf("vec%0d_ovf", i), 32'(rovf), 32'(vecs[i].exp_ovf));
`endif
      check_output($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      check_output($sformatf("vec%0d_busy_cycles", i), 32'(busy_cnt), 32'd4);
    end

    $display("[TB] randomized operations");
    for (int n = 0; n < 40; n++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rci  = 1'($urandom);
`ifdef SOMADOR_SUB_EN
      rsub = 1'($urandom);
`else
      rsub = 1'b0;
`endif
      model(ra, rb, rci, rsub, ms, mco, movf);
      apply_stimulus(ra, rb, rci, rsub, rs, rco, rovf, lat, busy_cnt);
      check_output($sformatf("rand%0d_s", n), 32'(rs), 32'(ms));
      check_output($sformatf("rand%0d_co", n), 32'(rco), 32'(mco));
`ifdef SOMADOR_SUB_EN
      check_output($sformatf("rand%0d_ovf", n), 32'(rovf), 32'(movf));
`endif
      check_output($sformatf("rand%0d_latency", n), 32'(lat), 32'd4);
    end

    $display("[TB] single-bit instance");
    for (int i = 0; i < 8; i++) begin
      combo = 3'(i);
      apply_stimulus_w1(combo[2], combo[1], combo[0], res1, lat);
      check_output($sformatf("w1_combo%0d_result", i), 32'(res1), 32'(w1_exp[i]));
      check_output($sformatf("w1_combo%0d_latency", i), 32'(lat), 32'd1);
    end

    $display("[TB] back-to-back with start held");
    @(negedge clk);
    sub = 1'b0; a = 16'hFFFF; b = 16'h0001; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!done && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check_output("held_first_latency", 32'(lat), 32'd4);
    check_output("held_first_s", 32'(s), 32'h0000);
    check_output("held_first_co", 32'(co), 32'd1);
    a = 16'h0001; b = 16'h0001;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
      if (gap == 1) start = 1'b0;
      if (gap == 2) begin
        start = 1'b1; a = 16'h5555; b = 16'h5555; ci = 1'b1;
      end
      if (gap == 3) start = 1'b0;
    end while (!done && gap < 50);
    check_output("held_done_period", 32'(gap), 32'd5);
    check_output("held_second_s", 32'(s), 32'h0002);
    check_output("held_second_co", 32'(co), 32'd0);
    repeat (3) @(negedge clk);
    check_output("held_s_stable", 32'(s), 32'h0002);
    check_output("held_idle_busy", 32'(busy), 32'd0);
    check_output("held_idle_done", 32'(done), 32'd0);

    $display("[TB] reset during calculation");
    apply_stimulus(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, rs, rco, rovf, lat, busy_cnt);
    check_output("prereset_s", 32'(rs), 32'hFFFE);
    check_output("prereset_co", 32'(rco), 32'd1);
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_output("midcalc_busy", 32'(busy), 32'd1);
    check_output("midcalc_s_held", 32'(s), 32'hFFFE);
    rst_n = 1'b0;
    #1;
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_done", 32'(done), 32'd0);
    check_output("abort_s", 32'(s), 32'd0);
    check_output("abort_co", 32'(co), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check_output("abort_no_done", 32'(done_seen), 32'd0);
    apply_stimulus(16'h0F0F, 16'h00F1, 1'b1, 1'b0, rs, rco, rovf, lat, busy_cnt);
    check_output("postreset_s", 32'(rs), 32'h1001);
    check_output("postreset_co", 32'(rco), 32'd0);
    check_output("postreset_latency", 32'(lat), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
